// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package ctrl_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXECR     = 4'd6;
  localparam logic [3:0] S_EXECI     = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_JAL       = 4'd9;
  localparam logic [3:0] S_JALR      = 4'd10;
  localparam logic [3:0] S_JALR_LINK = 4'd11;
  localparam logic [3:0] S_BRANCH    = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_TRAP      = 4'd14;

  typedef enum logic [3:0] {
    FETCH     = S_FETCH,
    DECODE    = S_DECODE,
    MEMADR    = S_MEMADR,
    MEMREAD   = S_MEMREAD,
    MEMWB     = S_MEMWB,
    MEMWRITE  = S_MEMWRITE,
    EXECR     = S_EXECR,
    EXECI     = S_EXECI,
    ALUWB     = S_ALUWB,
    JAL       = S_JAL,
    JALR      = S_JALR,
    JALR_LINK = S_JALR_LINK,
    BRANCH    = S_BRANCH,
    LUI       = S_LUI,
    TRAP      = S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] RS_ALUOUT  = 2'b00;
  localparam logic [1:0] RS_READ    = 2'b01;
  localparam logic [1:0] RS_ALURES  = 2'b10;
  localparam logic [1:0] RS_IMM     = 2'b11;

  localparam logic [1:0] SA_PC      = 2'b00;
  localparam logic [1:0] SA_OLDPC   = 2'b01;
  localparam logic [1:0] SA_RD1     = 2'b10;

  localparam logic [1:0] SB_RD2     = 2'b00;
  localparam logic [1:0] SB_IMM     = 2'b01;
  localparam logic [1:0] SB_FOUR    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_LUI, OP_AUIPC:  return IMM_U;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for register and immediate ALU ops.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic       is_r;
  logic [3:0] code;

  always_comb begin
    is_r = (op == OP_R);
    code = ALU_ADD;
    case (funct3)
      // addi has no subtract form, so funct7 only matters for register ops
      3'd0:    code = (is_r && funct7) ? ALU_SUB : ALU_ADD;
      3'd1:    code = ALU_SLL;
      3'd2:    code = ALU_SLT;
      3'd3:    code = ALU_SLTU;
      3'd4:    code = ALU_XOR;
      3'd5:    code = funct7 ? ALU_SRA : ALU_SRL;
      3'd6:    code = ALU_OR;
      default: code = ALU_AND;
    endcase
    alu_ctrl = ALU_CTRL_W'(code);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM with memory handshake and bus watchdog.
// Optional performance counters enabled by defining MC_CONTROL_PERF_EN.
module mc_control
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic                  instr_done,
  output logic                  trap,
  output logic                  trap_cause
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit WD_EN = (TIMEOUT > 0);

  state_t                state_q, state_d;
  logic [CW-1:0]         wait_q;
  logic                  cause_q;
  logic                  wd_hit;
  logic                  req;
  logic                  br_take;
  logic [ALU_CTRL_W-1:0] dec_alu;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu)
  );

  always_comb begin
    case (funct3)
      3'b000:  br_take = zero;
      3'b001:  br_take = ~zero;
      3'b100:  br_take = lt;
      3'b101:  br_take = ~lt;
      3'b110:  br_take = ltu;
      3'b111:  br_take = ~ltu;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RS_ALUOUT;
    ALUSrcA    = SA_PC;
    ALUSrcB    = SB_RD2;
    ALUControl = ALU_CTRL_W'(ALU_ADD);
    ImmSrc     = IMM_SRC_W'(imm_src_of(op));
    case (state_q)
      FETCH: begin
        req       = 1'b1;
        ALUSrcB   = SB_FOUR;
        ResultSrc = RS_ALURES;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_IMM:            state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_BRANCH:         state_d = BRANCH;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = ALUWB;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        req    = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RS_READ;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        req      = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcA    = SA_RD1;
        ALUSrcB    = (state_q == EXECI) ? SB_IMM : SB_RD2;
        ALUControl = dec_alu;
        state_d    = ALUWB;
      end
      ALUWB: begin
        ResultSrc = RS_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        ALUSrcA   = SA_OLDPC;
        ALUSrcB   = SB_FOUR;
        ResultSrc = RS_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = ALUWB;
      end
      JALR: begin
        ALUSrcA   = SA_RD1;
        ALUSrcB   = SB_IMM;
        ResultSrc = RS_ALURES;
        PCWrite   = 1'b1;
        state_d   = JALR_LINK;
      end
      JALR_LINK: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_FOUR;
        state_d = ALUWB;
      end
      BRANCH: begin
        ALUSrcA    = SA_RD1;
        ALUSrcB    = SB_RD2;
        ALUControl = ALU_CTRL_W'(ALU_SUB);
        ResultSrc  = RS_ALUOUT;
        PCWrite    = br_take;
        state_d    = FETCH;
      end
      LUI: begin
        ResultSrc = RS_IMM;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        ImmSrc  = '0;
        state_d = TRAP;
      end
    endcase

    wd_hit = WD_EN && req && !mem_ready && (wait_q == WD_LAST);
    if (wd_hit) state_d = TRAP;

    mem_req    = req;
    instr_done = (state_q != FETCH) && (state_q != TRAP) && (state_d == FETCH);
    trap       = (state_q == TRAP);
    trap_cause = cause_q;

    // Outputs read inactive while reset is held, even though state is FETCH
    if (!rst_n) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = '0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ALUControl = '0;
      ImmSrc     = '0;
      instr_done = 1'b0;
      trap       = 1'b0;
      trap_cause = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || mem_ready) begin
        wait_q <= '0;
      end else if (req && wait_q != '1) begin
        wait_q <= wait_q + 1'b1;
      end
      if (state_q != TRAP && state_d == TRAP) cause_q <= wd_hit;
    end
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
